// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the dc_fifo write-port arbiter.
package fifo_arb_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = ST_IDLE,
      BURST = ST_BURST
   } state_e;

   // Index width for n sources; never narrower than one bit.
   function automatic int idw(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] onehot(input int idx, input int n);
      logic [31:0] v;
      v = '0;
      if (idx >= 0 && idx < n && idx < 32) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after last_i, wrapping around.
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_SRC = 4,
   parameter int IDW   = idw(N_SRC)
) (
   input  logic [N_SRC-1:0] req_i,
   input  logic [IDW-1:0]   last_i,
   output logic [N_SRC-1:0] gnt_o,
   output logic [IDW-1:0]   idx_o,
   output logic             any_o
);

   int          cand;
   logic        found;
   logic [31:0] oh;

   always_comb begin
      found = 1'b0;
      idx_o = '0;
      cand  = 0;
      for (int off = 1; off <= N_SRC; off++) begin
         cand = (int'(last_i) + off) % N_SRC;
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx_o = IDW'(cand);
         end
      end
   end

   assign oh    = onehot(int'(idx_o), N_SRC);
   assign gnt_o = found ? oh[N_SRC-1:0] : '0;
   assign any_o = found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the dc_fifo write port among N_SRC sources in bursts of up to BURST_LEN tagged words.
// One cycle to grant; during a burst ready/wr_req follow wr_full_i combinationally.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int  N_SRC       = 4,
   parameter int  DWIDTH      = 8,
   parameter int  AWIDTH      = 4,
   parameter int  BURST_LEN   = 4,
   parameter int  ALMOST_FULL = 12,
   localparam int IDW         = idw(N_SRC)
) (
   input  logic                    clk_i,
   input  logic                    aclr_n_i,
   input  logic [N_SRC-1:0]        src_valid_i,
   input  logic [N_SRC*DWIDTH-1:0] src_data_i,
   output logic [N_SRC-1:0]        src_ready_o,
   output logic [N_SRC-1:0]        grant_o,
   output logic                    busy_o,
   output logic                    wr_req_o,
   output logic [IDW+DWIDTH-1:0]   wr_data_o,
   input  logic                    wr_full_i,
   input  logic [AWIDTH-1:0]       wr_usedw_i
);

   localparam int              CW        = $clog2(BURST_LEN + 1);
   localparam int              AFW       = AWIDTH + 1;
   localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST_LEN - 1);
   localparam logic [AFW-1:0]  AF_TH     = AFW'(ALMOST_FULL);

   state_e            state_q, state_d;
   logic [N_SRC-1:0]  grant_q, grant_d;
   logic [IDW-1:0]    last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic [N_SRC-1:0]  arb_gnt;
   logic [IDW-1:0]    arb_idx;
   logic              arb_any;
   logic              in_burst;
   logic              own_vld;
   logic              xfer;
   logic              can_grant;
   logic [DWIDTH-1:0] own_dat;

   rr_arbiter #(
      .N_SRC (N_SRC),
      .IDW   (IDW)
   ) u_rr (
      .req_i  (src_valid_i),
      .last_i (last_q),
      .gnt_o  (arb_gnt),
      .idx_o  (arb_idx),
      .any_o  (arb_any)
   );

   // last_q doubles as the owner index while a burst is running.
   assign in_burst  = (state_q == BURST);
   assign own_vld   = src_valid_i[last_q];
   assign own_dat   = src_data_i[int'(last_q)*DWIDTH +: DWIDTH];
   assign xfer      = in_burst && own_vld && !wr_full_i;
   assign can_grant = arb_any && !wr_full_i && ({1'b0, wr_usedw_i} < AF_TH);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (can_grant) begin
               state_d = BURST;
               grant_d = arb_gnt;
               last_d  = arb_idx;
               cnt_d   = '0;
            end
         end
         BURST: begin
            // A dropped valid ends the burst even while the FIFO is full.
            if (!own_vld) begin
               state_d = IDLE;
               grant_d = '0;
               cnt_d   = '0;
            end else if (xfer) begin
               if (cnt_q == LAST_BEAT) begin
                  state_d = IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge aclr_n_i) begin
      if (!aclr_n_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDW'(N_SRC - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant_o     = grant_q;
   assign busy_o      = in_burst;
   assign src_ready_o = (in_burst && !wr_full_i) ? grant_q : '0;
   assign wr_req_o    = xfer;
   assign wr_data_o   = in_burst ? {last_q, own_dat} : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a rule model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int BL = 4;
   localparam int AF = 12;

   logic            clk = 1'b0;
   logic            aclr_n;
   logic [N-1:0]    src_valid;
   logic [N*DW-1:0] src_data;
   logic [N-1:0]    src_ready;
   logic [N-1:0]    grant;
   logic            busy;
   logic            wr_req;
   logic [DW+1:0]   wr_data;
   logic            wr_full;
   logic [AW-1:0]   usedw;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [DW-1:0] srcq [N][$];
   logic [DW+1:0] expq [N][$];
   int            log_cyc [$];
   logic [DW+1:0] log_dat [$];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .N_SRC       (N),
      .DWIDTH      (DW),
      .AWIDTH      (AW),
      .BURST_LEN   (BL),
      .ALMOST_FULL (AF)
   ) dut (
      .clk_i       (clk),
      .aclr_n_i    (aclr_n),
      .src_valid_i (src_valid),
      .src_data_i  (src_data),
      .src_ready_o (src_ready),
      .grant_o     (grant),
      .busy_o      (busy),
      .wr_req_o    (wr_req),
      .wr_data_o   (wr_data),
      .wr_full_i   (wr_full),
      .wr_usedw_i  (usedw)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic push_word(input int k, input logic [DW-1:0] d);
      srcq[k].push_back(d);
      expq[k].push_back({2'(k), d});
   endtask

   function automatic int pending();
      int s = 0;
      for (int k = 0; k < N; k++) s += srcq[k].size();
      return s;
   endfunction

   task automatic drain(input string nm);
      int n = 0;
      while ((pending() != 0 || busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_drain"}, 32'(n < 1000), 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_log(input int target, input string nm);
      int n = 0;
      while (log_cyc.size() < target && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check({nm, "_wait"}, 32'(log_cyc.size() >= target), 1);
   endtask

   task automatic do_reset();
      aclr_n  = 1'b0;
      wr_full = 1'b0;
      usedw   = '0;
      repeat (3) @(posedge clk);
      #1 aclr_n = 1'b1;
   endtask

   // Source side: each source presents the head of its queue until it is accepted.
   initial begin
      src_valid = '0;
      src_data  = '0;
      forever begin
         @(posedge clk); #2;
         for (int k = 0; k < N; k++) begin
            src_valid[k]         = (srcq[k].size() != 0);
            src_data[k*DW +: DW] = (srcq[k].size() != 0) ? srcq[k][0] : '0;
         end
      end
   end

   // Monitor: protocol rules, round-robin model and per-source scoreboard.
   initial begin : mon
      logic [N-1:0]  p_grant;
      logic [N-1:0]  p_valid;
      logic          p_full;
      logic          p_ownv;
      logic [AW-1:0] p_usedw;
      logic [DW+1:0] e;
      bit            p_ok;
      int            last;
      int            beats;
      int            w;
      int            tag;
      p_ok  = 1'b0;
      last  = N - 1;
      beats = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!aclr_n) begin
            p_ok  = 1'b0;
            last  = N - 1;
            beats = 0;
         end else begin
            check("grant_onehot", 32'($countones(grant) <= 1), 1);
            check("busy_vs_grant", 32'(busy), 32'(grant != '0));
            check("req_while_full", 32'(wr_req & wr_full), 0);
            check("req_vs_handshake", 32'(wr_req), 32'(|(src_valid & src_ready)));
            check("ready", 32'(src_ready), 32'(wr_full ? '0 : grant));
            if (!busy) check("idle_data", 32'(wr_data), 0);
            if (p_ok) begin
               if (p_grant == '0) begin
                  if (p_valid != '0 && !p_full && int'(p_usedw) < AF) begin
                     w = -1;
                     for (int o = 1; o <= N; o++)
                        if (w < 0 && p_valid[(last + o) % N]) w = (last + o) % N;
                     check("rr_grant", 32'(grant), 32'(1) << w);
                     last  = w;
                     beats = 0;
                  end else begin
                     check("no_grant", 32'(grant), 0);
                  end
               end else if (!p_ownv || beats == BL) begin
                  check("burst_end", 32'(grant), 0);
               end else begin
                  check("burst_hold", 32'(grant), 32'(p_grant));
               end
            end
            if (wr_req) begin
               tag = int'(wr_data[DW+1:DW]);
               beats++;
               check("tag_is_owner", 32'(tag), 32'(last));
               check("sb_pending", 32'(expq[tag].size() > 0), 1);
               if (expq[tag].size() > 0) begin
                  e = expq[tag].pop_front();
                  check("wr_data", 32'(wr_data), 32'(e));
               end
               log_cyc.push_back(cyc);
               log_dat.push_back(wr_data);
            end
            for (int k = 0; k < N; k++)
               if (src_valid[k] && src_ready[k] && srcq[k].size() > 0) srcq[k].delete(0);
            p_grant = grant;
            p_valid = src_valid;
            p_full  = wr_full;
            p_usedw = usedw;
            p_ownv  = src_valid[last];
            p_ok    = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base;
      aclr_n  = 1'b0;
      wr_full = 1'b0;
      usedw   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", 32'(grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(src_ready), 0);
      check("rst_wr_req", 32'(wr_req), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      aclr_n = 1'b1;

      // Idle with no requests.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t1_grant", 32'(grant), 0);
         check("t1_wr_req", 32'(wr_req), 0);
         check("t1_busy", 32'(busy), 0);
         check("t1_wr_data", 32'(wr_data), 0);
      end

      // Single source, six words: 4-beat burst, one idle cycle, 2-beat burst.
      @(posedge clk); #1;
      base = log_cyc.size();
      for (int j = 0; j < 6; j++) push_word(2, 8'h11 + 8'(j));
      drain("t2");
      check("t2_count", 32'(log_cyc.size() - base), 6);
      if (log_cyc.size() >= base + 6) begin
         for (int j = 0; j < 6; j++) begin
            check("t2_data", 32'(log_dat[base+j]), 32'h211 + 32'(j));
            if (j > 0) check("t2_gap", 32'(log_cyc[base+j] - log_cyc[base+j-1]), (j == 4) ? 2 : 1);
         end
      end

      // All four sources busy from reset: grants 0,1,2,3,0,1,2,3.
      do_reset();
      base = log_cyc.size();
      for (int k = 0; k < N; k++)
         for (int j = 0; j < 8; j++) push_word(k, 8'(k * 16 + j));
      drain("t3");
      check("t3_count", 32'(log_cyc.size() - base), 32);
      if (log_cyc.size() >= base + 32) begin
         for (int i = 0; i < 32; i++) begin
            check("t3_tag", 32'(log_dat[base+i][DW+1:DW]), 32'((i / 4) % 4));
            if (i > 0) check("t3_gap", 32'(log_cyc[base+i] - log_cyc[base+i-1]), (i % 4 == 0) ? 2 : 1);
         end
      end

      // FIFO full for three cycles after the second beat.
      base = log_cyc.size();
      for (int j = 0; j < 4; j++) push_word(1, 8'h41 + 8'(j));
      wait_log(base + 2, "t4");
      @(posedge clk); #1 wr_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_stall_req", 32'(wr_req), 0);
         check("t4_stall_ready", 32'(src_ready), 0);
         check("t4_stall_grant", 32'(grant), 32'h2);
      end
      @(posedge clk); #1 wr_full = 1'b0;
      drain("t4");
      check("t4_count", 32'(log_cyc.size() - base), 4);
      if (log_cyc.size() >= base + 4) begin
         check("t4_beat3", 32'(log_dat[base+2]), 32'h143);
         check("t4_beat4", 32'(log_dat[base+3]), 32'h144);
         check("t4_stall_gap", 32'(log_cyc[base+2] - log_cyc[base+1]), 4);
      end

      // Almost-full threshold holds off the grant.
      usedw = 4'd12;
      push_word(1, 8'h51);
      push_word(1, 8'h52);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t5_held", 32'(grant), 0);
      end
      @(posedge clk); #1 usedw = 4'd11;
      @(negedge clk);
      check("t5_same_cycle", 32'(grant), 0);
      @(negedge clk);
      check("t5_grant", 32'(grant), 32'h2);
      check("t5_wr_req", 32'(wr_req), 1);
      check("t5_wr_data", 32'(wr_data), 32'h151);
      @(posedge clk); #1 usedw = '0;
      drain("t5");

      // Asynchronous reset during beat 2 of a source-3 burst.
      base = log_cyc.size();
      for (int j = 0; j < 4; j++) push_word(3, 8'h61 + 8'(j));
      wait_log(base + 1, "t6");
      @(posedge clk); #3 aclr_n = 1'b0;
      #1;
      check("t6_grant", 32'(grant), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_ready", 32'(src_ready), 0);
      check("t6_wr_req", 32'(wr_req), 0);
      check("t6_wr_data", 32'(wr_data), 0);
      push_word(0, 8'h71);
      push_word(0, 8'h72);
      @(posedge clk);
      @(posedge clk); #1 aclr_n = 1'b1;
      for (int n = 0; n < 20 && grant == '0; n++) @(negedge clk);
      check("t6_first_winner", 32'(grant), 32'h1);
      drain("t6");

      // Randomized traffic with random full / usedw.
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++)
            if ($urandom_range(0, 3) == 0 && srcq[k].size() < 6) push_word(k, 8'($urandom));
         wr_full = ($urandom_range(0, 4) == 0);
         usedw   = 4'($urandom_range(0, 15));
         @(posedge clk); #1;
      end
      wr_full = 1'b0;
      usedw   = '0;
      drain("rand");
      for (int k = 0; k < N; k++) check("sb_empty", 32'(expq[k].size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
